// File: rtl/muldiv_ctrl.sv
// HI/LO owner and launch/commit sequencer for the iterative mul/div unit.
// Holds the EX stage while a HI/LO op cannot complete; watchdog aborts hangs.
module muldiv_ctrl #(
    parameter int TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        op_valid,
    input  logic [2:0]  op,
    input  logic        mf_hi,
    input  logic [31:0] rs_data,
    input  logic [31:0] rt_data,
    input  logic        cpu_stall,
    output logic [1:0]  calc,
    output logic [31:0] calc_a,
    output logic [31:0] calc_b,
    output logic        calc_start,
    input  logic [31:0] calc_hi,
    input  logic [31:0] calc_lo,
    input  logic        calc_done,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] mf_data,
    output logic        stall_req,
    output logic        busy,
    output logic        timeout_err
);

    localparam logic [1:0] CAL_MULT  = 2'd0;
    localparam logic [1:0] CAL_MULTU = 2'd1;
    localparam logic [1:0] CAL_DIV   = 2'd2;
    localparam logic [1:0] CAL_DIVU  = 2'd3;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_WAIT   = 2'd2;

    localparam int WDW = $clog2(TIMEOUT);
    localparam logic [WDW-1:0] WD_LAST = WDW'(TIMEOUT - 1);

    logic [1:0]     state_q, state_d;
    logic [31:0]    hi_q, hi_d;
    logic [31:0]    lo_q, lo_d;
    logic [31:0]    calc_a_q, calc_a_d;
    logic [31:0]    calc_b_q, calc_b_d;
    logic [1:0]     calc_q, calc_d;
    logic [WDW-1:0] wd_q, wd_d;
    logic           terr_q, terr_d;

    logic       is_md;
    logic       is_div;
    logic [1:0] md_cal;
    logic       accept;
    logic       launch;

    // Classify the presented op into mul/div kinds and their datapath code.
    always_comb begin
        is_md  = 1'b0;
        is_div = 1'b0;
        md_cal = CAL_MULTU;
        unique case (op)
            OP_MULT:  begin is_md = 1'b1; md_cal = CAL_MULT;  end
            OP_MULTU: begin is_md = 1'b1; md_cal = CAL_MULTU; end
            OP_DIV:   begin is_md = 1'b1; is_div = 1'b1; md_cal = CAL_DIV;  end
            OP_DIVU:  begin is_md = 1'b1; is_div = 1'b1; md_cal = CAL_DIVU; end
            default:  ;
        endcase
    end

    assign stall_req   = op_valid & (op != OP_NOP) & (state_q != S_IDLE);
    assign busy        = (state_q != S_IDLE);
    assign accept      = op_valid & ~cpu_stall & ~stall_req;
    // A zero divisor retires immediately and leaves HI/LO alone.
    assign launch      = accept & is_md & ~(is_div & (rt_data == 32'd0));
    assign calc_start  = (state_q == S_LAUNCH);
    assign calc        = calc_q;
    assign calc_a      = calc_a_q;
    assign calc_b      = calc_b_q;
    assign hi          = hi_q;
    assign lo          = lo_q;
    assign mf_data     = mf_hi ? hi_q : lo_q;
    assign timeout_err = terr_q;

    // Next-state: launch, commit, watchdog abort and MT writes.
    always_comb begin
        state_d  = state_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        calc_a_d = calc_a_q;
        calc_b_d = calc_b_q;
        calc_d   = calc_q;
        wd_d     = wd_q;
        terr_d   = terr_q;
        unique case (state_q)
            S_IDLE: begin
                if (launch) begin
                    calc_a_d = rs_data;
                    calc_b_d = rt_data;
                    calc_d   = md_cal;
                    state_d  = S_LAUNCH;
                end
                if (accept && op == OP_MTHI) hi_d = rs_data;
                if (accept && op == OP_MTLO) lo_d = rs_data;
            end
            S_LAUNCH: begin
                wd_d    = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (calc_done) begin
                    hi_d    = calc_hi;
                    lo_d    = calc_lo;
                    state_d = S_IDLE;
                end else if (!cpu_stall) begin
                    if (wd_q == WD_LAST) begin
                        terr_d  = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        wd_d = wd_q + 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            hi_q     <= '0;
            lo_q     <= '0;
            calc_a_q <= '0;
            calc_b_q <= '0;
            calc_q   <= CAL_MULTU;
            wd_q     <= '0;
            terr_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            calc_a_q <= calc_a_d;
            calc_b_q <= calc_b_d;
            calc_q   <= calc_d;
            wd_q     <= wd_d;
            terr_q   <= terr_d;
        end
    end

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Scoreboard bench for muldiv_ctrl with a stub iterative datapath
// and an arithmetic reference model of HI/LO.
module tb_muldiv_ctrl;

    localparam logic [1:0] CAL_MULT  = 2'd0;
    localparam logic [1:0] CAL_MULTU = 2'd1;
    localparam logic [1:0] CAL_DIV   = 2'd2;
    localparam logic [1:0] CAL_DIVU  = 2'd3;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;
    localparam logic [2:0] OP_MF    = 3'd7;

    logic        clk;
    logic        reset;
    logic        op_valid;
    logic [2:0]  op;
    logic        mf_hi;
    logic [31:0] rs_data, rt_data;
    logic        cpu_stall;
    logic [1:0]  calc;
    logic [31:0] calc_a, calc_b;
    logic        calc_start;
    logic [31:0] calc_hi, calc_lo;
    logic        calc_done;
    logic [31:0] hi, lo, mf_data;
    logic        stall_req, busy, timeout_err;

    muldiv_ctrl #(.TIMEOUT(16)) dut (
        .clk(clk), .reset(reset), .op_valid(op_valid), .op(op),
        .mf_hi(mf_hi), .rs_data(rs_data), .rt_data(rt_data),
        .cpu_stall(cpu_stall), .calc(calc), .calc_a(calc_a),
        .calc_b(calc_b), .calc_start(calc_start), .calc_hi(calc_hi),
        .calc_lo(calc_lo), .calc_done(calc_done), .hi(hi), .lo(lo),
        .mf_data(mf_data), .stall_req(stall_req), .busy(busy),
        .timeout_err(timeout_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { logic [1:0] cal; logic [31:0] a; logic [31:0] b; } launch_t;
    typedef struct { logic [31:0] hi; logic [31:0] lo; logic terr; } res_t;

    launch_t lq[$];
    res_t    rq[$];
    int n_vec = 0;
    int n_err = 0;

    logic [31:0] m_hi, m_lo;
    logic        m_terr;

    int  stub_lat = 4;
    bit  stub_never = 0;
    bit  stub_kick = 0;
    bit  stub_pend = 0;
    int  stub_cnt = 0;
    logic [63:0] stub_res;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic fail(input string nm);
        n_vec++;
        n_err++;
        $display("FAIL %s: event not expected or never arrived", nm);
    endtask

    // Kinds: 0 MULT, 1 MULTU, 2 DIV, 3 DIVU. Result is {hi, lo}.
    function automatic logic [63:0] ref_calc(input int k, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, q, r;
        logic [63:0] p;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = 64'h0;
        case (k)
            0: p = 64'(sa * sb);
            1: p = {32'h0, a} * {32'h0, b};
            2: if (b != 0) begin q = sa / sb; r = sa % sb; p = {r[31:0], q[31:0]}; end
            3: if (b != 0) p = {a % b, a / b};
            default: ;
        endcase
        return p;
    endfunction

    function automatic logic [1:0] cal_of(input int k);
        case (k)
            0: return CAL_MULT;
            1: return CAL_MULTU;
            2: return CAL_DIV;
            default: return CAL_DIVU;
        endcase
    endfunction

    function automatic int kind_of(input logic [1:0] c);
        for (int k = 0; k < 4; k++) if (cal_of(k) == c) return k;
        return 0;
    endfunction

    // Stub datapath: computes from what the controller hands it, replies after stub_lat cycles.
    always @(posedge clk) begin
        #2;
        calc_done = 1'b0;
        calc_hi = $urandom;
        calc_lo = $urandom;
        if (stub_kick) begin
            calc_done = 1'b1;
            stub_kick = 0;
        end
        if (stub_pend) begin
            stub_cnt--;
            if (stub_cnt == 0) begin
                calc_done = 1'b1;
                {calc_hi, calc_lo} = stub_res;
                stub_pend = 0;
            end
        end
        if (calc_start) begin
            stub_res = ref_calc(kind_of(calc), calc_a, calc_b);
            stub_cnt = stub_lat;
            stub_pend = !stub_never;
        end
    end

    // Monitor: pops expected launches and commits as the DUT presents them.
    bit prev_busy = 0;
    always @(negedge clk) begin
        if (reset) begin
            prev_busy = 0;
        end else begin
            if (calc_start) begin
                if (lq.size() == 0) fail("launch_unexpected");
                else begin
                    launch_t le;
                    le = lq.pop_front();
                    chk("calc", calc, le.cal);
                    chk("calc_a", calc_a, le.a);
                    chk("calc_b", calc_b, le.b);
                end
            end
            if (prev_busy && !busy) begin
                if (rq.size() == 0) fail("commit_unexpected");
                else begin
                    res_t re;
                    re = rq.pop_front();
                    chk("commit_hi", hi, re.hi);
                    chk("commit_lo", lo, re.lo);
                    chk("commit_terr", timeout_err, re.terr);
                end
            end
            prev_busy = busy;
        end
    end

    // Reference model: applied at the edge where the op is accepted.
    task automatic model_accept(input logic [2:0] o, input logic mh, input logic [31:0] a,
                                input logic [31:0] b, output bit launched);
        logic [63:0] p;
        launched = 0;
        if (o >= OP_MULT && o <= OP_DIVU) begin
            if (!((o == OP_DIV || o == OP_DIVU) && b == 0)) begin
                launched = 1;
                lq.push_back('{cal: cal_of(int'(o) - 1), a: a, b: b});
                if (stub_never) begin
                    m_terr = 1'b1;
                end else begin
                    p = ref_calc(int'(o) - 1, a, b);
                    m_hi = p[63:32];
                    m_lo = p[31:0];
                end
                rq.push_back('{hi: m_hi, lo: m_lo, terr: m_terr});
            end
        end else if (o == OP_MTHI) m_hi = a;
        else if (o == OP_MTLO) m_lo = a;
        else if (o == OP_MF) chk(mh ? "mfhi" : "mflo", mf_data, mh ? m_hi : m_lo);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Presents an op until accepted; starts and ends just after a rising edge.
    task automatic issue(input logic [2:0] o, input logic mh, input logic [31:0] a,
                         input logic [31:0] b, input bit rnd_stall,
                         output bit launched, output int nstall);
        bit acc = 0;
        nstall = 0;
        launched = 0;
        op_valid = 1'b1; op = o; mf_hi = mh; rs_data = a; rt_data = b;
        for (int t = 0; t < 200 && !acc; t++) begin
            cpu_stall = rnd_stall ? ($urandom_range(0, 3) == 0) : 1'b0;
            @(negedge clk);
            if (!stall_req && !cpu_stall) begin
                acc = 1;
                model_accept(o, mh, a, b, launched);
            end else if (stall_req) nstall++;
            @(posedge clk);
            #1;
        end
        if (!acc) fail("accept_wait");
        op_valid = 1'b0;
        cpu_stall = 1'b0;
    endtask

    task automatic run_to_idle(input bit launched, output int nb);
        nb = 0;
        @(negedge clk);
        chk("start_pulse", calc_start, launched);
        for (int t = 0; t < 100 && busy; t++) begin
            nb++;
            @(negedge clk);
        end
        if (busy) fail("idle_wait");
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset();
        chk("rst_hi", hi, 0);
        chk("rst_lo", lo, 0);
        chk("rst_calc_a", calc_a, 0);
        chk("rst_calc_b", calc_b, 0);
        chk("rst_calc", calc, CAL_MULTU);
        chk("rst_start", calc_start, 0);
        chk("rst_busy", busy, 0);
        chk("rst_stall", stall_req, 0);
        chk("rst_terr", timeout_err, 0);
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_terr = 0;
        lq.delete();
        rq.delete();
    endtask

    initial begin
        #1000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit l;
        int ns, nb;
        logic [2:0] o;
        logic [31:0] a, b;
        reset = 1'b1; op_valid = 0; op = 0; mf_hi = 0;
        rs_data = 0; rt_data = 0; cpu_stall = 0;
        calc_done = 0; calc_hi = 0; calc_lo = 0;
        model_reset();
        repeat (2) @(negedge clk);
        check_reset();
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Signed multiply, 8-cycle datapath.
        stub_lat = 8;
        issue(OP_MULT, 0, 32'hFFFFFFFD, 32'd5, 0, l, ns);
        run_to_idle(l, nb);
        chk("mult_busy_cycles", nb, 9);
        chk("mult_hi", hi, 32'hFFFFFFFF);
        chk("mult_lo", lo, 32'hFFFFFFF1);

        // DIVU followed by a stalled MFHI, then MFLO.
        stub_lat = 6;
        issue(OP_DIVU, 0, 32'd100, 32'd7, 0, l, ns);
        issue(OP_MF, 1, 0, 0, 0, l, ns);
        chk("mfhi_stall_cycles", ns, 7);
        chk("divu_hi", hi, 2);
        issue(OP_MF, 0, 0, 0, 0, l, ns);
        chk("divu_lo", mf_data, 14);

        // Zero divisor after MTHI/MTLO.
        issue(OP_MTHI, 0, 32'h11, 0, 0, l, ns);
        issue(OP_MTLO, 0, 32'h22, 0, 0, l, ns);
        issue(OP_DIV, 0, 32'd5, 32'd0, 0, l, ns);
        chk("div0_stall", ns, 0);
        run_to_idle(l, nb);
        chk("div0_busy", nb, 0);
        chk("div0_hi", hi, 32'h11);
        chk("div0_lo", lo, 32'h22);

        // MULTU presented while a DIV is in flight.
        stub_lat = 10;
        issue(OP_DIV, 0, -32'sd100, 32'd9, 0, l, ns);
        step(3);
        issue(OP_MULTU, 0, 32'hFFFFFFFF, 32'd2, 0, l, ns);
        chk("multu_stall_cycles", ns, 8);
        run_to_idle(l, nb);
        chk("multu_busy_cycles", nb, 11);
        chk("multu_hi", hi, 32'h1);

        // Watchdog abort and an ignored late done.
        stub_never = 1;
        issue(OP_MULT, 0, 32'd3, 32'd4, 0, l, ns);
        run_to_idle(l, nb);
        stub_never = 0;
        chk("timeout_busy_cycles", nb, 17);
        chk("timeout_err", timeout_err, 1);
        stub_kick = 1;
        step(3);
        chk("late_done_hi", hi, m_hi);
        chk("late_done_lo", lo, m_lo);
        chk("late_done_busy", busy, 0);

        // Reset during WAIT with done arriving right after release.
        stub_lat = 8;
        issue(OP_MULT, 0, 32'd9, 32'd9, 0, l, ns);
        step(3);
        reset = 1'b1;
        model_reset();
        step(5);
        reset = 1'b0;
        @(negedge clk);
        check_reset();
        @(negedge clk);
        chk("post_rst_hi", hi, 0);
        chk("post_rst_lo", lo, 0);
        @(posedge clk);
        #1;
        issue(OP_MULT, 0, 32'd6, 32'd7, 0, l, ns);
        run_to_idle(l, nb);
        chk("mult67_lo", lo, 42);
        chk("mult67_hi", hi, 0);

        // Random ops, operands, latencies and external stalls.
        for (int i = 0; i < 80; i++) begin
            o = 3'($urandom_range(0, 7));
            a = $urandom;
            b = ($urandom_range(0, 4) == 0) ? 32'd0 :
                ($urandom_range(0, 1) == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            stub_lat = $urandom_range(1, 12);
            issue(o, 1'($urandom_range(0, 1)), a, b, 1, l, ns);
            if ($urandom_range(0, 1) == 0) run_to_idle(l, nb);
        end
        for (int t = 0; t < 100 && busy; t++) step(1);
        step(2);
        chk("launch_q_empty", lq.size(), 0);
        chk("result_q_empty", rq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
